clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider with a 50% duty-cycle output for both odd and even divisors.
- Successor to the fixed odd-only divide-by-N block.
- Adds:
  - divisor width as a parameter;
  - a valid/ready configuration port, with changes applied glitch-free at the output-period boundary;
  - an enable input and a period-start tick.
- Sits in the clock/reset utility layer and feeds low-speed peripheral clocks and strobes.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_halfext.sv | 26 ++
 rtl/clk_div_prog.sv | 132 +++++++++++++
 tb/tb_clk_div_prog.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The divider keeps its run state as a small enum so it can be named in debug views.
package clk_div_pkg;

    localparam int MIN_DIV = 2;
    localparam int DEF_DW  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Number of whole clk cycles in which the posedge flop is high.
    function automatic int unsigned half_div(input int unsigned n);
        return n / 2;
    endfunction

endpackage

// File: rtl/clk_div_halfext.sv
// Negedge half-cycle extender: the only negedge logic in the divider.
// For odd divisors the output stays high an extra half clk period.
module clk_div_halfext
    import clk_div_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clk_p,
    input  logic odd_div,
    output logic clk_out
);

    logic clk_n_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_p;
        end
    end

    // Pure OR of two flops; clk itself never reaches clk_out.
    assign clk_out = odd_div ? (clk_p | clk_n_q) : clk_p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even divisors.
// New divisors are staged and take effect only where an output period begins.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int DEF_DIV = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_div,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          tick,
    output logic [DW-1:0] cur_div
);

    localparam logic [DW-1:0] ONE     = DW'(1);
    localparam logic [DW-1:0] MIN_VAL = DW'(MIN_DIV);

    run_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          clk_p_q, clk_p_d;
    logic          tick_q, tick_d;
    logic          cfg_err_q, cfg_err_d;
    logic          pending_q, pending_d;
    logic [DW-1:0] pend_div_q, pend_div_d;
    logic [DW-1:0] cur_div_q, cur_div_d;

    logic [DW-1:0] half;
    logic [DW-1:0] cnt_inc;
    logic          boundary;

    assign half     = DW'(half_div(32'(cur_div_q)));
    assign cnt_inc  = cnt_q + ONE;
    assign boundary = (cnt_q == (cur_div_q - ONE));

    // Config handshake: a divisor transfers on any posedge where cfg_valid and
    // cfg_ready are both high; the master holds cfg_div stable until then.
    assign cfg_ready = !pending_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_p_d    = clk_p_q;
        tick_d     = 1'b0;
        cfg_err_d  = 1'b0;
        pending_d  = pending_q;
        pend_div_d = pend_div_q;
        cur_div_d  = cur_div_q;

        if (state_q == ST_IDLE) begin
            // A stopped divider picks up a staged divisor straight away.
            if (pending_q) begin
                cur_div_d = pend_div_q;
                pending_d = 1'b0;
            end
            if (en) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                clk_p_d = 1'b1;
                tick_d  = 1'b1;
            end else begin
                clk_p_d = 1'b0;
            end
        end else if (!boundary) begin
            cnt_d   = cnt_inc;
            clk_p_d = (cnt_inc < half);
        end else begin
            cnt_d = '0;
            if (pending_q) begin
                cur_div_d = pend_div_q;
                pending_d = 1'b0;
            end
            if (en) begin
                clk_p_d = 1'b1;
                tick_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                clk_p_d = 1'b0;
            end
        end

        // Acceptance only happens with nothing staged, so it never collides with the apply above.
        if (cfg_valid && !pending_q) begin
            if (cfg_div < MIN_VAL) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_div_d = cfg_div;
                pending_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clk_p_q    <= 1'b0;
            tick_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pending_q  <= 1'b0;
            pend_div_q <= '0;
            cur_div_q  <= DW'(DEF_DIV);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_p_q    <= clk_p_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
            pending_q  <= pending_d;
            pend_div_q <= pend_div_d;
            cur_div_q  <= cur_div_d;
        end
    end

    clk_div_halfext u_halfext (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_p   (clk_p_q),
        .odd_div (cur_div_q[0]),
        .clk_out (clk_out)
    );

    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;
    assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios then random traffic,
// compared against a half-cycle-level behavioural model of the divided clock.
module tb_clk_div_prog;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          cfg_valid;
    logic [DW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;
    logic          clk_out;
    logic          tick;
    logic [DW-1:0] cur_div;

    clk_div_prog #(.DW(DW), .DEF_DIV(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a period of N clk cycles is 2N half-cycles, and the
    // output is high for exactly the first N of them (odd or even N alike).
    bit m_run;
    int m_pos;
    int m_div;
    bit m_pend;
    int m_pend_val;
    bit m_tick;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_div = 3; m_pend = 0; m_pend_val = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_posedge(input bit en_s, input bit val_s, input int div_s);
        bit accept_ok;
        accept_ok = val_s && !m_pend;
        m_tick = 0;
        m_err  = 0;
        if (!m_run) begin
            if (m_pend) begin m_div = m_pend_val; m_pend = 0; end
            if (en_s) begin m_run = 1; m_pos = 0; m_tick = 1; end
        end else if (m_pos != m_div - 1) begin
            m_pos++;
        end else begin
            if (m_pend) begin m_div = m_pend_val; m_pend = 0; end
            m_pos = 0;
            if (en_s) m_tick = 1;
            else m_run = 0;
        end
        if (accept_ok) begin
            if (div_s < 2) m_err = 1;
            else begin m_pend = 1; m_pend_val = div_s; end
        end
    endtask

    function automatic logic exp_out(input int half_idx);
        return (m_run && (2 * m_pos + half_idx < m_div)) ? 1'b1 : 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_posedge(en, cfg_valid, int'(cfg_div));
        #1;
        check("clk_out_hi_half", 32'(clk_out), 32'(exp_out(0)));
        check("tick", 32'(tick), 32'(m_tick));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check("cur_div", 32'(cur_div), 32'(m_div));
        @(negedge clk);
        #1;
        check("clk_out_lo_half", 32'(clk_out), 32'(exp_out(1)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer_once(input int d);
        cfg_valid = 1'b1;
        cfg_div   = DW'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    // Hold the offer until the model says it was taken; bounded wait.
    task automatic offer_hold(input int d);
        bit taken;
        taken     = 0;
        cfg_valid = 1'b1;
        cfg_div   = DW'(d);
        for (int i = 0; i < 600 && !taken; i++) begin
            taken = !m_pend;
            step();
        end
        cfg_valid = 1'b0;
        check("offer_accepted", 32'(taken), 32'd1);
    endtask

    task automatic wait_pos(input int div_v, input int pos_v);
        bit hit;
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            step();
            hit = m_run && (m_div == div_v) && (m_pos == pos_v);
        end
        check("wait_pos_reached", 32'(hit), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_cur_div", 32'(cur_div), 32'd3);
        rst_n = 1'b1;
        run(2);

        // Default divide-by-3, starts on the first posedge with en high.
        en = 1'b1;
        run(9);

        // Switch to 4 mid-period.
        run(1);
        offer_once(4);
        run(12);

        // 7 then 5 back-to-back: 5 waits until 7 is applied.
        offer_once(7);
        offer_hold(5);
        run(20);

        // Illegal divisors are flagged and dropped.
        offer_once(0);
        run(2);
        offer_once(1);
        run(4);

        // Graceful disable with N=6, dropped at cnt=1.
        offer_hold(6);
        wait_pos(6, 1);
        en = 1'b0;
        run(8);
        en = 1'b1;
        run(8);

        // Asynchronous reset during the high phase with N=5.
        offer_hold(5);
        wait_pos(5, 1);
        check("pre_rst_high", 32'(clk_out), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_clk_out", 32'(clk_out), 32'd0);
        check("mid_rst_cur_div", 32'(cur_div), 32'd3);
        check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("mid_rst_tick", 32'(tick), 32'd0);
        #1;
        rst_n = 1'b1;
        run(10);

        // Extremes of the legal range.
        offer_hold(2);
        run(8);
        offer_hold(255);
        run(520);

        // Reconfigure while stopped.
        en = 1'b0;
        run(260);
        offer_once(4);
        run(3);
        en = 1'b1;
        run(10);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div   = DW'($urandom_range(0, 12));
            step();
        end
        cfg_valid = 1'b0;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
